// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the HI/LO multiply/divide unit
package muldiv_pkg;

  // Operation codes as decoded in D and sampled with start.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Divide-class ops use the longer latency.
  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_alu.sv
// rtl/muldiv_alu.sv - combinational HI/LO result for one multiply/divide op
//   i_op        : operation code
//   i_a, i_b    : operands (rs, rt)
//   i_hi, i_lo  : HI/LO accumulator input (madd/msub source, div-by-0 hold value)
//   o_hi, o_lo  : new HI/LO
module muldiv_alu
  import muldiv_pkg::*;
(
  input  md_op_t      i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic        [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [63:0] w_acc;
  logic        [63:0] w_res;
  logic               w_signed_div;
  logic        [31:0] w_a_mag;
  logic        [31:0] w_b_mag;
  logic        [31:0] w_num;
  logic        [31:0] w_den;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic        [31:0] w_q;
  logic        [31:0] w_r;

  assign w_sa    = {{32{i_a[31]}}, i_a};
  assign w_sb    = {{32{i_b[31]}}, i_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};
  assign w_acc   = {i_hi, i_lo};

  // One unsigned divider serves both div and divu; signed division runs on
  // magnitudes and fixes signs afterwards. 0x80000000 has magnitude
  // 0x80000000 as unsigned, so the /-1 overflow case falls out naturally.
  assign w_signed_div = (i_op == MD_DIV);
  assign w_a_mag      = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_b_mag      = i_b[31] ? (32'd0 - i_b) : i_b;
  assign w_num        = w_signed_div ? w_a_mag : i_a;
  // Divisor forced to 1 when zero so the divider never sees x/0; the result
  // is discarded in that case anyway.
  assign w_den        = (i_b == 32'd0) ? 32'd1 : (w_signed_div ? w_b_mag : i_b);
  assign w_q_mag      = w_num / w_den;
  assign w_r_mag      = w_num % w_den;
  assign w_q = (w_signed_div && (i_a[31] ^ i_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r = (w_signed_div && i_a[31])             ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_res = w_acc;
    case (i_op)
      MD_MULT:  w_res = w_sprod;
      MD_MULTU: w_res = w_uprod;
      MD_MADD:  w_res = w_acc + w_sprod;
      MD_MADDU: w_res = w_acc + w_uprod;
      MD_MSUB:  w_res = w_acc - w_sprod;
      MD_MSUBU: w_res = w_acc - w_uprod;
      MD_DIV, MD_DIVU: begin
        if (i_b != 32'd0) w_res = {w_r, w_q};
      end
      default:  w_res = w_acc;
    endcase
  end

  assign o_hi = w_res[63:32];
  assign o_lo = w_res[31:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle HI/LO multiply/divide unit with sequencing controller
//   clk, reset   : clock, async active-high reset
//   start, op    : launch request and op code (ignored while busy or with flush)
//   a, b         : operands sampled with start
//   mthi, mtlo   : write wdata to HI/LO, only in idle with start low
//   flush        : abort in-flight op without commit
//   busy, done   : op in flight / pulse in last busy cycle (commit at its end)
//   hi, lo       : architectural HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_t   r_state;
  md_state_t   w_state_n;
  logic [CW-1:0] r_cnt;
  md_op_t      r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi_in;
  logic [31:0] r_lo_in;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  md_op_t      w_op;
  logic        w_launch;
  logic        w_commit;
  logic [31:0] w_hi_n;
  logic [31:0] w_lo_n;

  assign w_op = md_op_t'(op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_launch  = 1'b0;
    w_commit  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush && (w_op != MD_NONE)) begin
          w_launch  = 1'b1;
          w_state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // Flush wins over completion, including in the final cycle.
        if (flush) begin
          w_state_n = ST_IDLE;
        end else if (r_cnt == '0) begin
          done      = 1'b1;
          w_commit  = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= MD_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_hi_in <= '0;
      r_lo_in <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_launch) begin
        r_op    <= w_op;
        r_a     <= a;
        r_b     <= b;
        r_hi_in <= r_hi;
        r_lo_in <= r_lo;
        r_cnt   <= is_div(w_op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (w_commit) begin
        r_hi <= w_hi_n;
        r_lo <= w_lo_n;
      end else if ((r_state == ST_IDLE) && !start) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  muldiv_alu u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .i_hi (r_hi_in),
    .i_lo (r_lo_in),
    .o_hi (w_hi_n),
    .o_lo (w_lo_n)
  );

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with a behavioural HI/LO model
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] ref_md(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h,
                                         input logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, acc, res;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    acc = {h, l};
    res = acc;
    case (o)
      4'd1: res = sx * sy;
      4'd2: res = ux * uy;
      4'd3: if (y != 0) begin
              q = sx / sy;
              r = sx % sy;
              res = {r[31:0], q[31:0]};
            end
      4'd4: if (y != 0) res = {x % y, x / y};
      4'd5: res = acc + 64'(sx * sy);
      4'd6: res = acc + ux * uy;
      4'd7: res = acc - 64'(sx * sy);
      4'd8: res = acc - ux * uy;
      default: res = acc;
    endcase
    return res;
  endfunction

  function automatic int lat(input logic [3:0] o);
    return (o == 4'd3 || o == 4'd4) ? DC : MC;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic expect_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = ref_md(o, x, y, m_hi, m_lo);
    exp_q.push_back(r);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  // Full op: start one cycle, then count busy cycles and locate done.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int nb, dat, n;
    n = lat(o);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    expect_op(o, x, y);
    nb = 0; dat = 0;
    for (int k = 1; k <= n + 5; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (done) dat = k;
    end
    check("busy_cycles", 64'(nb), 64'(n));
    check("done_cycle", 64'(dat), 64'(n));
  endtask

  task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
    @(posedge clk); #1;
    mthi = wh; mtlo = wl; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Monitor: on every done pulse pop the expected result and compare the
  // HI/LO visible in the following cycle.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("commit", {hi, lo}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed examples.
    do_op(4'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(4'd4, 32'd7, 32'd2);
    check("divu_7_2", {hi, lo}, 64'h0000_0001_0000_0003);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    mt(1'b1, 1'b0, 32'd0);
    mt(1'b0, 1'b1, 32'd10);
    do_op(4'd5, 32'd3, 32'd4);
    check("madd_lo", {hi, lo}, 64'd22);
    do_op(4'd8, 32'hFFFF_FFFF, 32'd2);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    do_op(4'd3, 32'd1234, 32'd0);
    check("div_by_zero_hold", {hi, lo}, 64'h0000_0011_0000_0022);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    mt(1'b1, 1'b1, 32'h5A5A_0001);
    check("mt_both", {hi, lo}, 64'h5A5A_0001_5A5A_0001);

    // Dropped writes and a second start while busy.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd1; a = 32'd6; b = 32'd7; mthi = 1'b1; wdata = 32'hDEAD_0000;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; mthi = 1'b0;
    expect_op(4'd1, 32'd6, 32'd7);
    @(posedge clk); #1;
    mtlo = 1'b1; wdata = 32'hBEEF_0000;
    @(posedge clk); #1;
    mtlo = 1'b0; start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    wait_idle();
    @(negedge clk);
    check("drops_result", {hi, lo}, 64'd42);

    // Back-to-back: start in the done cycle ignored, accepted one cycle later.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    expect_op(4'd1, 32'd3, 32'd5);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b1; op = 4'd2; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    check("b2b_not_in_done_cycle", 64'(busy), 64'd0);
    expect_op(4'd2, 32'd7, 32'd9);
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    check("b2b_accepted", 64'(busy), 64'd1);
    wait_idle();

    // Flush mid-op.
    mt(1'b1, 1'b1, 32'h0BAD_F00D);
    @(posedge clk); #1;
    start = 1'b1; op = 4'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});

    // Flush in the final cycle.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd7; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MC - 1) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_last_done", 64'(done), 64'd0);
    check("flush_last_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_last_idle", 64'(busy), 64'd0);
    check("flush_last_hilo", {hi, lo}, {m_hi, m_lo});

    // Start together with flush in idle is dropped.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_dropped", 64'(busy), 64'd0);

    // Async reset mid-op.
    @(posedge clk); #1;
    start = 1'b1; op = 4'd3; a = 32'd50; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized ops and HI/LO writes.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        ro = 4'($urandom_range(1, 8));
        ra = pick();
        rb = pick();
        if ((ro == 4'd3 || ro == 4'd4) && $urandom_range(0, 7) == 0) rb = 32'd0;
        do_op(ro, ra, rb);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_hilo", {hi, lo}, {m_hi, m_lo});
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
